// File: rtl/mips_dmem_mmio.sv
// mips_dmem_mmio: data-side memory for the single-cycle MIPS core.
// Decodes the core's word address into a word RAM and memory-mapped
// peripherals (16-bit GPIO, prescaled down-counting timer with interrupt).
// Loads are combinational. Stores commit on the rising clk edge.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   reset      asynchronous, active-high reset
//   memwrite   store strobe from core
//   addr       byte address (core aluout), addr[1:0] ignored
//   writedata  store data from core
//   readdata   load data, combinational from addr
//   gpio_in    external inputs, asynchronous to clk
//   gpio_out   registered GPIO output
//   irq        timer interrupt, level, active-high
module mips_dmem_mmio #(
    parameter int unsigned RAM_AW   = 6,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        irq
);

    localparam logic [31:0] A_GPIO_OUT  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPIO_IN   = 32'hFFFF_0004;
    localparam logic [31:0] A_TMR_LOAD  = 32'hFFFF_0010;
    localparam logic [31:0] A_TMR_COUNT = 32'hFFFF_0014;
    localparam logic [31:0] A_TMR_CTRL  = 32'hFFFF_0018;
    localparam logic [31:0] A_TMR_STAT  = 32'hFFFF_001C;

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;
    localparam logic [15:0] PS_LAST   = 16'(PRESCALE - 1);

    // ---------------- address decode ----------------
    logic [31:0]       w_word;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_ram_we;
    logic              w_we_gpio;
    logic              w_we_load;
    logic              w_we_count;
    logic              w_we_ctrl;
    logic              w_we_stat;
    logic              w_unused;

    assign w_word     = {addr[31:2], 2'b00};
    assign w_ram_idx  = addr[RAM_AW+1:2];
    assign w_ram_we   = memwrite & ~addr[31];
    assign w_we_gpio  = memwrite & (w_word == A_GPIO_OUT);
    assign w_we_load  = memwrite & (w_word == A_TMR_LOAD);
    assign w_we_count = memwrite & (w_word == A_TMR_COUNT);
    assign w_we_ctrl  = memwrite & (w_word == A_TMR_CTRL);
    assign w_we_stat  = memwrite & (w_word == A_TMR_STAT);
    assign w_unused   = ^addr[1:0];

    // ---------------- RAM (not reset) ----------------
    logic [31:0] r_ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_ram_idx] <= writedata;
    end

    // ---------------- GPIO ----------------
    logic [15:0] r_gpio_out;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_we_gpio) r_gpio_out <= writedata[15:0];
        end
    end

    assign gpio_out = r_gpio_out;

    // ---------------- timer ----------------
    logic [15:0] r_presc;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_en;
    logic        r_ar;
    logic        r_ie;
    logic        r_expired;
    logic        w_tick;
    logic        w_expire;

    assign w_tick   = r_en && (r_presc == PS_LAST);
    assign w_expire = w_tick && (r_count == '0);

    // Later assignments in this block override earlier ones: CPU writes to
    // COUNT/CTRL follow the tick update so they win, while the hardware set
    // of expired follows the W1C clear so expiry wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc   <= '0;
            r_load    <= '0;
            r_count   <= '0;
            r_en      <= 1'b0;
            r_ar      <= 1'b0;
            r_ie      <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            if (!r_en || w_tick) r_presc <= '0;
            else                 r_presc <= r_presc + 16'd1;

            if (w_tick) begin
                if (r_count != '0) r_count <= r_count - 32'd1;
                else if (r_ar)     r_count <= r_load;
                else               r_en    <= 1'b0;
            end

            if (w_we_load)  r_load  <= writedata;
            if (w_we_count) r_count <= writedata;
            if (w_we_ctrl) begin
                r_en <= writedata[0];
                r_ar <= writedata[1];
                r_ie <= writedata[2];
            end

            if (w_we_stat && writedata[0]) r_expired <= 1'b0;
            if (w_expire)                  r_expired <= 1'b1;
        end
    end

    assign irq = r_expired & r_ie;

    // ---------------- read mux ----------------
    always_comb begin
        readdata = '0;
        if (!addr[31]) begin
            readdata = r_ram[w_ram_idx];
        end else begin
            case (w_word)
                A_GPIO_OUT:  readdata = {16'h0000, r_gpio_out};
                A_GPIO_IN:   readdata = {16'h0000, r_sync2};
                A_TMR_LOAD:  readdata = r_load;
                A_TMR_COUNT: readdata = r_count;
                A_TMR_CTRL:  readdata = {29'd0, r_ie, r_ar, r_en};
                A_TMR_STAT:  readdata = {31'd0, r_expired};
                default:     readdata = '0;
            endcase
        end
    end

endmodule
